// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: one write per rx_done rising edge,
// registered read port with a one-cycle rd_valid pulse, sticky overflow on dropped bytes.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  input  logic                  rd_en,
  input  logic                  clr_overflow,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  rx_done_q;

  logic wr_stb, rd_acc, wr_acc, drop, is_full, is_empty;

  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);
  assign wr_stb   = rx_done & ~rx_done_q;
  assign rd_acc   = rd_en & ~is_empty;
  // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign wr_acc   = wr_stb & (~is_full | rd_acc);
  assign drop     = wr_stb & is_full & ~rd_acc;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      // Preset high so an rx_done already high at release is not seen as a new byte.
      rx_done_q  <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      rx_done_q  <= rx_done;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign empty    = is_empty;
  assign full     = is_full;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver wrapper.
- Captures each received byte on the rising edge of the receiver's `rx_done` and stores it in a circular FIFO.
- Presents stored bytes to the consumer logic through a registered read port.
- Decouples byte arrival from consumer timing and flags lost bytes with a sticky overflow bit.

Parameters:
- DATA_WIDTH, 8, width of one received byte and of each FIFO entry.
- ADDR_WIDTH, 4, pointer width; FIFO depth = 2**ADDR_WIDTH (16 entries).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx_data  input  DATA_WIDTH  byte from the UART receiver; must be stable while rx_done is high.
- rx_done  input  1  receiver byte-complete level; may stay high for several clk cycles.
- rd_en  input  1  consumer read request, sampled each clk.
- rd_data  output  DATA_WIDTH  registered read data; holds its value between reads.
- rd_valid  output  1  one-cycle pulse: rd_data updated this cycle.
- empty  output  1  count == 0.
- full  output  1  count == 2**ADDR_WIDTH.
- count  output  ADDR_WIDTH+1  number of stored bytes.
- overflow  output  1  sticky flag: at least one byte was dropped.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - rd_data=0, rd_valid=0, overflow=0.
  - empty=1, full=0.
  - Internal rx_done delay register = 1, so a high rx_done at reset release does not cause a write.
- Reset release:
  - Synchronous deassertion is handled outside this block.
  - The block is operational on the first clk edge with reset=1.
- Write strobe:
  - wr_stb = rx_done & ~rx_done_d, where rx_done_d is rx_done registered on clk.
  - Exactly one write per rx_done high period, regardless of how long it stays high.
- Write:
  - Condition: wr_stb and (not full, or read accepted in the same cycle).
  - Action: mem[wr_ptr] <= rx_data; wr_ptr increments and wraps from 2**ADDR_WIDTH-1 to 0.
- Read accept:
  - Condition: rd_en and not empty.
  - Next edge: rd_data <= mem[rd_ptr], rd_valid=1, rd_ptr increments with wrap.
  - Latency: 1 clk from rd_en to data.
- rd_en while empty: ignored. rd_valid=0, rd_data unchanged, no flag change.
- count update per cycle:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous write and read, or on neither.
  - Never exceeds 2**ADDR_WIDTH and never goes below 0.
- Full with wr_stb and no read accepted:
  - Byte dropped; pointers and memory unchanged.
  - overflow <= 1.
- Full with wr_stb and read accepted in the same cycle:
  - Both are performed; count stays at full; no overflow.
- Empty with wr_stb and rd_en in the same cycle:
  - Only the write happens; the new byte is not readable until the next cycle (no fall-through).
- overflow:
  - Sticky.
  - Cleared by clr_overflow=1 on the next edge.
  - If a drop occurs in the same cycle as clr_overflow, the set wins and overflow=1.
- Flags: empty and full are decoded from the registered count, so they are valid in the same cycle as count.
- Reset mid-operation: all stored bytes are discarded immediately; any pending read is lost (no rd_valid).
- Memory array is not reset; contents are undefined until written.

Test Plan:
- Reset, then 3 rx_done pulses carrying 0x41, 0x42, 0x43 (each held high 4 clk) -> count=3. Then rd_en for 3 cycles -> rd_valid pulses with rd_data 0x41, 0x42, 0x43, one cycle after each rd_en; empty=1; count=0.
- Write 16 bytes 0x00..0x0F -> full=1, count=16. A 17th byte 0xFF -> dropped, overflow=1, count=16. Read all 16 -> data 0x00..0x0F in order, 0xFF never appears.
- With full=1, assert rd_en in the same cycle as a write strobe with 0xAA -> rd_data=oldest byte, count stays 16, overflow stays 0. 0xAA is read last.
- rd_en held high with FIFO empty for 5 cycles -> rd_valid=0, rd_data unchanged. Then write 0x5A while rd_en=1 -> 0x5A appears on rd_data one cycle later (not in the write cycle).
- Pointer wrap: write and read 40 bytes 0x00..0x27 interleaved so count stays at or below 3 -> output sequence exact, no overflow.
- Hold rx_done=1 across reset assertion and release -> no write after release. Assert reset=0 with count=5 mid-stream -> count=0, empty=1, rd_valid=0 immediately, without waiting for a clk edge. Set overflow, then drive clr_overflow together with a new drop -> overflow stays 1; clr_overflow alone -> overflow=0.
